// File: rtl/vm2_vic_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vm2_irq_pkg
// Brief   : Shared types and constants for the VM2 vectored-interrupt arbiter.
// Revision: 1.0
// ============================================================================
package vm2_irq_pkg;

   localparam int VEC_W = 16;
   localparam logic [VEC_W-1:0] SPUR_VEC_DEF = 16'o0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      ACK     = 2'd2,
      RELEASE = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/vm2_vic_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : vm2_vic_arbiter_if
// Brief   : CPU-side vectored-interrupt handshake (virq/istb/ivec/iack).
// Revision: 1.0
// ============================================================================
interface vm2_vic_arbiter_if;
   import vm2_irq_pkg::*;

   logic             virq;
   logic             istb;
   logic             iack;
   logic [VEC_W-1:0] ivec;

   modport slave  (output virq, output iack, output ivec, input istb);
   modport master (input virq, input iack, input ivec, output istb);

endinterface
`default_nettype wire

// File: rtl/vm2_vic_arbiter_prio_enc.sv
`default_nettype none
// ============================================================================
// Module  : vic_prio_enc
// Brief   : Fixed-priority encoder, lowest set index wins.
// Revision: 1.0
// ============================================================================
module vic_prio_enc
   import vm2_irq_pkg::*;
#(
   parameter int N     = 8,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   output logic             hit,
   output logic [IDX_W-1:0] idx
);

   // Scanning downward lets the lowest index overwrite any higher one.
   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            hit = 1'b1;
            idx = IDX_W'(i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/vm2_vic_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : vm2_vic_arbiter
// Brief   : N-source vectored-interrupt arbiter with post-ack source masking.
// Revision: 1.0
// ============================================================================
module vm2_vic_arbiter
   import vm2_irq_pkg::*;
#(
   parameter int               N        = 8,
   parameter logic [VEC_W-1:0] SPUR_VEC = SPUR_VEC_DEF,
   parameter int               MASK_CYC = 3
) (
   input  logic                 clk_p,
   input  logic                 rst_n,
   input  logic                 init,
   input  logic [N-1:0]         irq_i,
   input  logic [VEC_W*N-1:0]   vec_i,
   vm2_vic_arbiter_if.slave     cpu,
   output logic [N-1:0]         dev_ack
);

   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   state_t           state;
   state_t           state_nxt;
   logic             istb_q;
   logic [N-1:0]     masked;
   logic [N-1:0]     pend;
   logic             hit;
   logic [IDX_W-1:0] sel;

   assign pend = irq_i & ~masked;

   vic_prio_enc #(
      .N     (N),
      .IDX_W (IDX_W)
   ) u_prio_enc (
      .req (pend),
      .hit (hit),
      .idx (sel)
   );

   always_ff @(posedge clk_p or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else if (init) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A new fetch needs a fresh istb rising edge, so a strobe held across init
   // is not granted again until the CPU lowers it.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cpu.istb && !istb_q) state_nxt = GRANT;
         GRANT:   state_nxt = ACK;
         ACK:     if (!cpu.istb) state_nxt = RELEASE;
         RELEASE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_p or negedge rst_n) begin
      if (!rst_n) begin
         istb_q   <= 1'b1;
         cpu.virq <= 1'b0;
         cpu.iack <= 1'b0;
         cpu.ivec <= '0;
         dev_ack  <= '0;
      end else if (init) begin
         istb_q   <= 1'b1;
         cpu.virq <= 1'b0;
         cpu.iack <= 1'b0;
         cpu.ivec <= '0;
         dev_ack  <= '0;
      end else begin
         istb_q   <= cpu.istb;
         cpu.virq <= ((state == IDLE) || (state == GRANT)) ? (|pend) : 1'b0;
         dev_ack  <= '0;
         case (state)
            GRANT: begin
               cpu.iack <= 1'b1;
               if (hit) begin
                  cpu.ivec <= vec_i[VEC_W*int'(sel) +: VEC_W];
                  dev_ack  <= N'(1) << sel;
               end else begin
                  cpu.ivec <= SPUR_VEC;
               end
            end
            ACK: begin
               if (!cpu.istb) begin
                  cpu.iack <= 1'b0;
                  cpu.ivec <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Counters hold their armed value while the CPU sits in ACK, then run down.
   for (genvar i = 0; i < N; i++) begin : g_mask
      logic [2:0] cnt;
      logic       arm;

      assign arm       = (state == GRANT) && hit && (sel == IDX_W'(i));
      assign masked[i] = |cnt;

      always_ff @(posedge clk_p or negedge rst_n) begin
         if (!rst_n) begin
            cnt <= 3'd0;
         end else if (init) begin
            cnt <= 3'd0;
         end else if (arm) begin
            cnt <= 3'(MASK_CYC);
         end else if ((state != ACK) && (cnt != 3'd0)) begin
            cnt <= cnt - 3'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vm2_vic_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_vm2_vic_arbiter
// Brief   : Directed plus random stimulus against a cycle-level behavioural model.
// Revision: 1.0
// ============================================================================
module tb_vm2_vic_arbiter;
   import vm2_irq_pkg::*;

   localparam int          N        = 8;
   localparam int          MASK_CYC = 3;
   localparam logic [15:0] SPUR     = 16'o0;

   logic           clk_p = 1'b0;
   logic           rst_n = 1'b0;
   logic           init  = 1'b0;
   logic [N-1:0]   irq_i = '0;
   logic [16*N-1:0] vec_i = '0;
   logic [N-1:0]   dev_ack;

   vm2_vic_arbiter_if bus ();

   vm2_vic_arbiter #(
      .N        (N),
      .SPUR_VEC (SPUR),
      .MASK_CYC (MASK_CYC)
   ) dut (
      .clk_p   (clk_p),
      .rst_n   (rst_n),
      .init    (init),
      .irq_i   (irq_i),
      .vec_i   (vec_i),
      .cpu     (bus),
      .dev_ack (dev_ack)
   );

   always #5 clk_p = ~clk_p;

   int total  = 0;
   int passed = 0;
   int failed = 0;

   // Reference model: phase 0..3 walks idle/grant/ack/release; left[] is the
   // number of further cycles each source stays masked.
   int          m_phase;
   int          m_left [N];
   bit          m_needlow;
   logic        m_virq;
   logic        m_iack;
   logic [15:0] m_ivec;
   logic [N-1:0] m_dev;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_phase   = 0;
      foreach (m_left[i]) m_left[i] = 0;
      m_needlow = 1'b1;
      m_virq    = 1'b0;
      m_iack    = 1'b0;
      m_ivec    = '0;
      m_dev     = '0;
   endfunction

   function automatic void model_step();
      logic [N-1:0] pend;
      int           w;
      int           nl [N];
      if (init) begin
         model_reset();
         return;
      end
      for (int i = 0; i < N; i++) pend[i] = irq_i[i] && (m_left[i] == 0);
      w = -1;
      for (int i = 0; i < N; i++) if (pend[i] && w < 0) w = i;
      m_virq = (m_phase <= 1) ? (pend != 0) : 1'b0;
      m_dev  = '0;
      for (int i = 0; i < N; i++) nl[i] = (m_phase != 2 && m_left[i] > 0) ? m_left[i] - 1 : m_left[i];
      case (m_phase)
         0: if (bus.istb && !m_needlow) m_phase = 1;
         1: begin
            m_iack = 1'b1;
            if (w >= 0) begin
               m_ivec   = vec_i[16*w +: 16];
               m_dev[w] = 1'b1;
               nl[w]    = MASK_CYC;
            end else begin
               m_ivec = SPUR;
            end
            m_phase = 2;
         end
         2: if (!bus.istb) begin
            m_iack  = 1'b0;
            m_ivec  = '0;
            m_phase = 3;
         end
         default: m_phase = 0;
      endcase
      for (int i = 0; i < N; i++) m_left[i] = nl[i];
      m_needlow = bus.istb;
   endfunction

   task automatic cycle();
      @(posedge clk_p);
      if (!rst_n) model_reset();
      else        model_step();
      @(negedge clk_p);
      check("virq",    32'(bus.virq), 32'(m_virq));
      check("iack",    32'(bus.iack), 32'(m_iack));
      check("ivec",    32'(bus.ivec), 32'(m_ivec));
      check("dev_ack", 32'(dev_ack),  32'(m_dev));
   endtask

   task automatic wait_virq();
      for (int k = 0; k < 60 && !bus.virq; k++) cycle();
      check("virq_wait", 32'(bus.virq), 32'd1);
   endtask

   // Returns at the first ACK cycle with the fetched vector and device pulse,
   // then steps through RELEASE back to IDLE.
   task automatic handshake(input bit drop, output logic [15:0] v, output logic [N-1:0] d);
      wait_virq();
      bus.istb = 1'b1;
      cycle();
      bus.istb = 1'b0;
      cycle();
      v = bus.ivec;
      d = dev_ack;
      check("hs_iack_latency", 32'(bus.iack), 32'd1);
      if (drop) irq_i = irq_i & ~d;
      cycle();
      cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [15:0]  v;
      logic [N-1:0] d;
      bit           seen;

      bus.istb = 1'b0;
      model_reset();

      // Reset with every request high
      irq_i = 8'hFF;
      repeat (3) cycle();
      check("rst_virq", 32'(bus.virq), 32'd0);
      check("rst_ivec", 32'(bus.ivec), 32'd0);
      irq_i = '0;
      rst_n = 1'b1;
      repeat (2) cycle();

      // Single request on source 3
      vec_i[16*3 +: 16] = 16'o060;
      irq_i[3] = 1'b1;
      handshake(1'b1, v, d);
      check("single_ivec", 32'(v), 32'(16'o060));
      check("single_dev",  32'(d), 32'h08);
      check("single_dev_pulse", 32'(dev_ack), 32'd0);
      repeat (4) cycle();
      check("single_virq_idle", 32'(bus.virq), 32'd0);

      // Three simultaneous requests served in priority order
      vec_i[16*2 +: 16] = 16'o100;
      vec_i[16*5 +: 16] = 16'o300;
      vec_i[16*7 +: 16] = 16'o360;
      irq_i = 8'b1010_0100;
      handshake(1'b1, v, d);
      check("prio_1st", 32'(v), 32'(16'o100));
      handshake(1'b1, v, d);
      check("prio_2nd", 32'(v), 32'(16'o300));
      handshake(1'b1, v, d);
      check("prio_3rd", 32'(v), 32'(16'o360));
      check("prio_dev", 32'(d), 32'h80);
      repeat (3) cycle();

      // Slow device holding irq for 2 cycles after its ack
      irq_i = 8'h04;
      handshake(1'b0, v, d);
      irq_i = '0;
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         cycle();
         seen |= bus.virq;
      end
      check("slow2_no_regrant", 32'(seen), 32'd0);

      // Holding for 6 cycles outlasts the mask and gets a second grant
      irq_i = 8'h04;
      handshake(1'b0, v, d);
      repeat (4) cycle();
      check("slow6_virq", 32'(bus.virq), 32'd1);
      handshake(1'b1, v, d);
      check("slow6_ivec", 32'(v), 32'(16'o100));
      check("slow6_dev",  32'(d), 32'h04);
      repeat (4) cycle();

      // Request withdrawn before the fetch
      vec_i[16*0 +: 16] = 16'o200;
      irq_i = 8'h01;
      cycle();
      check("spur_virq", 32'(bus.virq), 32'd1);
      irq_i = '0;
      bus.istb = 1'b1;
      cycle();
      bus.istb = 1'b0;
      cycle();
      check("spur_ivec", 32'(bus.ivec), 32'(SPUR));
      check("spur_iack", 32'(bus.iack), 32'd1);
      check("spur_dev",  32'(dev_ack),  32'd0);
      repeat (3) cycle();

      // init while in ACK with istb held
      vec_i[16*1 +: 16] = 16'o500;
      irq_i = 8'h02;
      wait_virq();
      bus.istb = 1'b1;
      repeat (2) cycle();
      check("init_pre_iack", 32'(bus.iack), 32'd1);
      cycle();
      init = 1'b1;
      cycle();
      init = 1'b0;
      check("init_iack", 32'(bus.iack), 32'd0);
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cycle();
         seen |= bus.iack;
      end
      check("init_no_regrant", 32'(seen), 32'd0);
      check("init_mask_clear", 32'(bus.virq), 32'd1);
      bus.istb = 1'b0;
      cycle();
      bus.istb = 1'b1;
      cycle();
      bus.istb = 1'b0;
      cycle();
      check("init_refetch_ivec", 32'(bus.ivec), 32'(16'o500));
      check("init_refetch_dev",  32'(dev_ack),  32'h02);
      irq_i = '0;
      repeat (4) cycle();

      // Random traffic against the model
      for (int k = 0; k < 400; k++) begin
         if (k % 50 == 0) vec_i = {$urandom, $urandom, $urandom, $urandom};
         irq_i    = N'($urandom);
         bus.istb = ($urandom_range(0, 2) == 0);
         init     = ($urandom_range(0, 40) == 0);
         cycle();
      end
      init     = 1'b0;
      bus.istb = 1'b0;
      irq_i    = '0;
      repeat (6) cycle();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
